// File: rtl/raccoon_sram_target_if.sv
// Raccoon ring + local SRAM port bundle for the raccoon_sram_target node.
// The slave modport is the target's view; master is the surrounding ring/SRAM.
interface raccoon_sram_target_if #(
  parameter int unsigned SIZE_LOG2 = 12
);
  localparam int unsigned RACC_W = 79;
  localparam int unsigned AW     = SIZE_LOG2 - 2;

  logic [RACC_W-1:0] RaccIn;
  logic [RACC_W-1:0] RaccOut;
  logic              SRAM_CE;
  logic              SRAM_WE;
  logic [3:0]        SRAM_BE;
  logic [AW-1:0]     SRAM_ADDR;
  logic [31:0]       SRAM_WDATA;
  logic [31:0]       SRAM_RDATA;

  modport slave (
    input  RaccIn,
    input  SRAM_RDATA,
    output RaccOut,
    output SRAM_CE,
    output SRAM_WE,
    output SRAM_BE,
    output SRAM_ADDR,
    output SRAM_WDATA
  );

  modport master (
    output RaccIn,
    output SRAM_RDATA,
    input  RaccOut,
    input  SRAM_CE,
    input  SRAM_WE,
    input  SRAM_BE,
    input  SRAM_ADDR,
    input  SRAM_WDATA
  );
endinterface

// File: rtl/raccoon_sram_target.sv
// Raccoon ring target: claims requests in [ADDR_BASE, ADDR_BASE + 2^SIZE_LOG2),
// performs them on a local single-port SRAM and injects an ack response.
// Everything else (and hits arriving while busy) is forwarded unchanged.
// Optional: RACCOON_TARGET_FASTWR_EN acknowledges write hits in their own slot.
module raccoon_sram_target #(
  parameter logic [31:0] ADDR_BASE = 32'h0001_0000,
  parameter int unsigned SIZE_LOG2 = 12
) (
  input  logic                  CLK,
  input  logic                  RST,
  raccoon_sram_target_if.slave  bus
);

  localparam int unsigned RACC_W = 79;
  localparam int unsigned AW     = SIZE_LOG2 - 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  logic [1:0]        state, state_n;
  logic [RACC_W-1:0] racc_in;
  logic [RACC_W-1:0] racc_out, racc_out_n;
  logic              sram_ce, sram_ce_n;
  logic              sram_we, sram_we_n;
  logic [3:0]        sram_be, sram_be_n;
  logic [AW-1:0]     sram_addr, sram_addr_n;
  logic [31:0]       sram_wdata, sram_wdata_n;

  // Latched transaction context for the response packet.
  logic              t_wr, t_wr_n;
  logic [7:0]        t_id, t_id_n;
  logic [3:0]        t_mask, t_mask_n;
  logic [31:0]       t_data, t_data_n;
  logic [31:0]       t_addr, t_addr_n;

  logic in_valid, in_wr, in_ack, hit;

  assign in_valid = racc_in[78];
  assign in_wr    = racc_in[77];
  assign in_ack   = racc_in[76];
  assign hit      = in_valid & ~in_ack &
                    (racc_in[31:SIZE_LOG2] == ADDR_BASE[31:SIZE_LOG2]);

  assign bus.RaccOut    = racc_out;
  assign bus.SRAM_CE    = sram_ce;
  assign bus.SRAM_WE    = sram_we;
  assign bus.SRAM_BE    = sram_be;
  assign bus.SRAM_ADDR  = sram_addr;
  assign bus.SRAM_WDATA = sram_wdata;

  // Register ring input, outputs, transaction context and FSM state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      racc_in    <= '0;
      racc_out   <= '0;
      sram_ce    <= 1'b0;
      sram_we    <= 1'b0;
      sram_be    <= 4'h0;
      sram_addr  <= '0;
      sram_wdata <= 32'h0;
      t_wr       <= 1'b0;
      t_id       <= 8'h0;
      t_mask     <= 4'h0;
      t_data     <= 32'h0;
      t_addr     <= 32'h0;
    end else begin
      state      <= state_n;
      racc_in    <= bus.RaccIn;
      racc_out   <= racc_out_n;
      sram_ce    <= sram_ce_n;
      sram_we    <= sram_we_n;
      sram_be    <= sram_be_n;
      sram_addr  <= sram_addr_n;
      sram_wdata <= sram_wdata_n;
      t_wr       <= t_wr_n;
      t_id       <= t_id_n;
      t_mask     <= t_mask_n;
      t_data     <= t_data_n;
      t_addr     <= t_addr_n;
    end
  end

  // Next-state and next-output decode; default is to forward the slot.
  always_comb begin
    state_n      = state;
    racc_out_n   = in_valid ? racc_in : '0;
    sram_ce_n    = 1'b0;
    sram_we_n    = sram_we;
    sram_be_n    = sram_be;
    sram_addr_n  = sram_addr;
    sram_wdata_n = sram_wdata;
    t_wr_n       = t_wr;
    t_id_n       = t_id;
    t_mask_n     = t_mask;
    t_data_n     = t_data;
    t_addr_n     = t_addr;

    case (state)
      ST_IDLE: begin
        if (hit) begin
          sram_ce_n    = 1'b1;
          sram_we_n    = in_wr;
          sram_be_n    = in_wr ? racc_in[67:64] : 4'hF;
          sram_addr_n  = AW'(racc_in[SIZE_LOG2-1:2]);
          sram_wdata_n = racc_in[63:32];
          t_wr_n       = in_wr;
          t_id_n       = racc_in[75:68];
          t_mask_n     = racc_in[67:64];
          t_data_n     = racc_in[63:32];
          t_addr_n     = racc_in[31:0];
          racc_out_n   = '0;
          state_n      = ST_ACCESS;
`ifdef RACCOON_TARGET_FASTWR_EN
          // Write hit turns into its own ack in place; no slot is consumed.
          if (in_wr) begin
            racc_out_n     = racc_in;
            racc_out_n[76] = 1'b1;
            state_n        = ST_IDLE;
          end
`endif
        end
      end
      ST_ACCESS: begin
        state_n = t_wr ? ST_RESP : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        t_data_n = bus.SRAM_RDATA;
        state_n  = ST_RESP;
      end
      ST_RESP: begin
        // Pass-through traffic keeps the slot; inject on the first empty one.
        if (!in_valid) begin
          racc_out_n = {1'b1, t_wr, 1'b1, t_id, t_mask, t_data, t_addr};
          state_n    = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_raccoon_sram_target.sv
// Directed self-checking bench for raccoon_sram_target.
// Honours RACCOON_TARGET_FASTWR_EN for write-ack timing expectations.
module tb_raccoon_sram_target;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  raccoon_sram_target_if bus ();

  raccoon_sram_target dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [78:0] pkt(input logic v, input logic w, input logic a,
                                      input logic [7:0] id, input logic [3:0] m,
                                      input logic [31:0] d, input logic [31:0] ad);
    return {v, w, a, id, m, d, ad};
  endfunction

  task automatic chk(input string tag, input logic [78:0] obs, input logic [78:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Write hit on an idle ring, checking SRAM strobe and ack timing.
  task automatic do_write(input string tag, input logic [7:0] id, input logic [31:0] ad,
                          input logic [3:0] m, input logic [31:0] d, input logic [9:0] wa);
    logic [78:0] req;
    logic [78:0] ack;
    req = pkt(1'b1, 1'b1, 1'b0, id, m, d, ad);
    ack = pkt(1'b1, 1'b1, 1'b1, id, m, d, ad);
    bus.RaccIn = req;
    step();
    bus.RaccIn = '0;
    step();
    chk({tag, "_ce"},    79'(bus.SRAM_CE),    79'(1'b1));
    chk({tag, "_we"},    79'(bus.SRAM_WE),    79'(1'b1));
    chk({tag, "_be"},    79'(bus.SRAM_BE),    79'(m));
    chk({tag, "_addr"},  79'(bus.SRAM_ADDR),  79'(wa));
    chk({tag, "_wdata"}, 79'(bus.SRAM_WDATA), 79'(d));
`ifdef RACCOON_TARGET_FASTWR_EN
    chk({tag, "_ack1"},  bus.RaccOut, ack);
    step();
    chk({tag, "_ce_off"}, 79'(bus.SRAM_CE), 79'(1'b0));
    chk({tag, "_empty"},  bus.RaccOut, 79'd0);
`else
    chk({tag, "_slot1"}, bus.RaccOut, 79'd0);
    step();
    chk({tag, "_ce_off"}, 79'(bus.SRAM_CE), 79'(1'b0));
    chk({tag, "_slot2"},  bus.RaccOut, 79'd0);
    step();
    chk({tag, "_ack3"},   bus.RaccOut, ack);
    step();
    chk({tag, "_after"},  bus.RaccOut, 79'd0);
`endif
  endtask

  initial begin
    logic [78:0] r1, r2, miss, resp, t;
    checks = 0;
    errors = 0;
    RST = 1'b0;
    bus.RaccIn = '0;
    bus.SRAM_RDATA = 32'h1234_5678;

    // Reset state.
    #1 RST = 1'b1;
    #2;
    chk("rst_raccout", bus.RaccOut, 79'd0);
    chk("rst_ce",      79'(bus.SRAM_CE),    79'd0);
    chk("rst_we",      79'(bus.SRAM_WE),    79'd0);
    chk("rst_be",      79'(bus.SRAM_BE),    79'd0);
    chk("rst_addr",    79'(bus.SRAM_ADDR),  79'd0);
    chk("rst_wdata",   79'(bus.SRAM_WDATA), 79'd0);
    step();
    RST = 1'b0;
    step();

    // Write hit.
    do_write("wr", 8'h02, 32'h0001_0010, 4'hF, 32'hDEAD_BEEF, 10'd4);
    step();

    // Read hit: ack with full RDATA word 4 edges after request.
    bus.RaccIn = pkt(1'b1, 1'b0, 1'b0, 8'h03, 4'b0011, 32'h0, 32'h0001_0010);
    step();
    bus.RaccIn = '0;
    step();
    chk("rd_ce",   79'(bus.SRAM_CE),   79'(1'b1));
    chk("rd_we",   79'(bus.SRAM_WE),   79'(1'b0));
    chk("rd_be",   79'(bus.SRAM_BE),   79'(4'hF));
    chk("rd_addr", 79'(bus.SRAM_ADDR), 79'(10'd4));
    step();
    chk("rd_ce_off", 79'(bus.SRAM_CE), 79'(1'b0));
    step();
    chk("rd_slot3", bus.RaccOut, 79'd0);
    step();
    chk("rd_ack4", bus.RaccOut,
        pkt(1'b1, 1'b0, 1'b1, 8'h03, 4'h3, 32'h1234_5678, 32'h0001_0010));
    step();

    // Miss and in-window response pass through unchanged.
    miss = pkt(1'b1, 1'b0, 1'b0, 8'h05, 4'hF, 32'h0, 32'h0002_0000);
    resp = pkt(1'b1, 1'b1, 1'b1, 8'h07, 4'h5, 32'hA5A5_0001, 32'h0001_0020);
    bus.RaccIn = miss;
    step();
    bus.RaccIn = resp;
    step();
    chk("miss_fwd", bus.RaccOut, miss);
    chk("miss_ce",  79'(bus.SRAM_CE), 79'(1'b0));
    bus.RaccIn = '0;
    step();
    chk("resp_fwd", bus.RaccOut, resp);
    chk("resp_ce",  79'(bus.SRAM_CE), 79'(1'b0));
    step();

    // Busy retry: second read hit one cycle behind the first.
    r1 = pkt(1'b1, 1'b0, 1'b0, 8'h04, 4'hF, 32'h0, 32'h0001_0010);
    r2 = pkt(1'b1, 1'b0, 1'b0, 8'h01, 4'hF, 32'h0, 32'h0001_0014);
    bus.RaccIn = r1;
    step();
    bus.RaccIn = r2;
    step();
    chk("busy_ce", 79'(bus.SRAM_CE), 79'(1'b1));
    bus.RaccIn = '0;
    step();
    chk("busy_retry", bus.RaccOut, r2);
    step();
    chk("busy_slot", bus.RaccOut, 79'd0);
    step();
    chk("busy_ack", bus.RaccOut,
        pkt(1'b1, 1'b0, 1'b1, 8'h04, 4'hF, 32'h1234_5678, 32'h0001_0010));
    step();

    // Slot contention: response waits for the first empty slot.
    t = pkt(1'b1, 1'b1, 1'b0, 8'h20, 4'hC, 32'h0BAD_CAFE, 32'h0003_0000);
    bus.RaccIn = pkt(1'b1, 1'b0, 1'b0, 8'h06, 4'h1, 32'h0, 32'h0001_0008);
    step();
    bus.RaccIn = t;
    step();
    chk("cont_consumed", bus.RaccOut, 79'd0);
    chk("cont_addr", 79'(bus.SRAM_ADDR), 79'(10'd2));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("cont_fwd", bus.RaccOut, t);
    end
    bus.RaccIn = '0;
    step();
    chk("cont_fwd_last", bus.RaccOut, t);
    step();
    chk("cont_ack", bus.RaccOut,
        pkt(1'b1, 1'b0, 1'b1, 8'h06, 4'h1, 32'h1234_5678, 32'h0001_0008));
    step();

    // Reset while in CAPTURE.
    bus.RaccIn = pkt(1'b1, 1'b0, 1'b0, 8'h09, 4'hF, 32'h0, 32'h0001_0040);
    step();
    bus.RaccIn = '0;
    step();
    step();
    #2 RST = 1'b1;
    #1;
    chk("mrst_raccout", bus.RaccOut, 79'd0);
    chk("mrst_ce",      79'(bus.SRAM_CE),    79'd0);
    chk("mrst_addr",    79'(bus.SRAM_ADDR),  79'd0);
    chk("mrst_be",      79'(bus.SRAM_BE),    79'd0);
    step();
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mrst_no_resp", bus.RaccOut, 79'd0);
    end

    // Service resumes; top word of the window with partial mask.
    do_write("wr2", 8'h0A, 32'h0001_0FFC, 4'b1010, 32'hCAFE_F00D, 10'h3FF);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/raccoon_sram_target.md
Name: raccoon_sram_target

Overview:
- Raccoon ring target node that sits downstream of the Tawas Raccoon master interface on the 79-bit ring.
- Claims requests whose address falls in its window and performs them on a local synchronous single-port SRAM.
- Converts each claimed request into an ack response that travels on around the ring to the issuing thread.
- Forwards every other packet unchanged. A request that arrives while the target is busy is also forwarded unchanged, so it returns to its master as a retry.

Parameters:
- ADDR_BASE, 32'h0001_0000, byte base address of the window; must be aligned to 2^SIZE_LOG2.
- SIZE_LOG2, 12, log2 of the window size in bytes. The SRAM holds 2^(SIZE_LOG2-2) words.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- RaccIn  in  79  ring input from the upstream node.
- RaccOut  out  79  ring output to the downstream node; registered.
- SRAM_CE  out  1  SRAM access strobe; registered.
- SRAM_WE  out  1  SRAM write enable; registered.
- SRAM_BE  out  4  SRAM byte enables; registered.
- SRAM_ADDR  out  SIZE_LOG2-2  SRAM word address; registered.
- SRAM_WDATA  out  32  SRAM write data; registered.
- SRAM_RDATA  in  32  SRAM read data; valid in the cycle after the clock edge that sampled SRAM_CE=1 with SRAM_WE=0.

Behaviour:
- Packet fields:
  - [78] valid, [77] write, [76] ack.
  - [75:68] ID, [67:64] byte mask.
  - [63:32] data, [31:0] address.
- RaccIn is registered into racc_in. All decode uses racc_in.
- Reset values: racc_in=0, RaccOut=0, SRAM_CE=0, SRAM_WE=0, SRAM_BE=0, SRAM_ADDR=0, SRAM_WDATA=0, state=IDLE.
- hit = racc_in[78] & ~racc_in[76] & (racc_in[31:SIZE_LOG2] == ADDR_BASE[31:SIZE_LOG2]).
- Forwarding: any valid packet that is not consumed goes to RaccOut unchanged on the next edge. This covers responses, misses, and hits while state != IDLE. An empty slot with nothing to inject outputs 79'd0.
- State IDLE:
  - On hit, latch wr, ID, mask, word address racc_in[SIZE_LOG2-1:2] and write data.
  - Drive SRAM_CE=1, SRAM_WE=wr, SRAM_BE=wr ? mask : 4'hF, SRAM_ADDR and SRAM_WDATA from the request.
  - RaccOut <= 0, because the slot is consumed.
  - Next state is ACCESS.
- State ACCESS: SRAM_CE <= 0. Next state is RESP for a write, CAPTURE for a read.
- State CAPTURE: response data <= SRAM_RDATA (the full 32-bit word, not masked or shifted). Next state is RESP.
- State RESP:
  - Pass-through traffic has priority.
  - On the first edge where racc_in[78]=0: RaccOut <= {1, wr, 1, ID, mask, data, original address}. Next state is IDLE.
  - Until then the target stays in RESP and forwards traffic.
  - For a write response, data is the original write data.
- Latency:
  - Write: ack on RaccOut 3 edges after the request is in racc_in, given a free slot.
  - Read: ack after 4 edges.
- Capacity is one outstanding transaction. Retries from a busy target are expected behaviour.
- Reset mid-transaction discards the pending access and response.
- Address bits [1:0] are ignored. Byte lanes are selected only by the mask.

Optional Feature:
- Macro: RACCOON_TARGET_FASTWR_EN.
- Defined:
  - A write hit in IDLE is acknowledged in its own slot: RaccOut <= racc_in with [76]=1.
  - The SRAM write is issued in the same cycle. State stays IDLE.
  - Writes take 1 edge and are never retried.
  - Reads are unchanged.
- Undefined: writes follow the ACCESS/RESP path described above.

Test Plan:
- Write hit: ID 8'h02, addr 32'h0001_0010, mask 4'hF, data 32'hDEAD_BEEF, idle ring.
  - SRAM_CE=1, WE=1, BE=F, ADDR=4, WDATA=DEADBEEF one edge later.
  - RaccOut ack {1,1,1,02,F,DEADBEEF,00010010} 3 edges after the request (1 edge with FASTWR).
- Read hit: read of addr 32'h0001_0010 with SRAM_RDATA=32'h1234_5678, mask 4'b0011.
  - Response data=12345678, mask=3, [76]=1, 4 edges after the request.
- Miss and pass-through: request to addr 32'h0002_0000, and response packets with [76]=1.
  - Appear bit-identical on RaccOut 1 edge later; SRAM_CE stays 0.
- Busy retry: second read hit (ID 8'h01) arrives one cycle after a first read hit.
  - Second request is forwarded unchanged with [76]=0; the first completes normally.
- Slot contention: continuous valid traffic held on RaccIn while in RESP.
  - No injection and all traffic forwarded; response appears on the first empty slot.
- Reset: RST asserted while in CAPTURE.
  - All outputs 0 immediately; no response is later emitted; the next hit is serviced normally.
